dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data width of every data bus.
REQ-002 Parameter DM_ADDRESS, default 9, data memory byte-address width.
REQ-003 Parameter MAX_WAIT, default 4, range 1..15, maximum number of consecutive cycles a pending aux request can lose to the core.
REQ-004 Ports, in this order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low.
- core_rd  in  1  MEM-stage read request.
- core_wr  in  1  MEM-stage write request.
- core_addr  in  DM_ADDRESS  MEM-stage address.
- core_wdata  in  DATA_W  MEM-stage store data.
- core_func3  in  3  MEM-stage access size/sign.
- core_rdata  out  DATA_W  read data returned to the MEM stage.
- core_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB this cycle.
- aux_valid  in  1  secondary requester (loader/debug) request.
- aux_we  in  1  aux request is a write (1) or a read (0).
- aux_addr  in  DM_ADDRESS  aux address.
- aux_wdata  in  DATA_W  aux store data.
- aux_func3  in  3  aux access size/sign.
- aux_ready  out  1  aux request accepted this cycle.
- aux_rvalid  out  1  aux read data valid.
- aux_rdata  out  DATA_W  aux read data.
- mem_rd  out  1  data memory read enable.
- mem_wr  out  1  data memory write enable.
- mem_addr  out  DM_ADDRESS  data memory address.
- mem_wdata  out  DATA_W  data memory write data.
- mem_func3  out  3  data memory func3.
- mem_rdata  in  DATA_W  data memory read data.
- aux_grants  out  16  saturating count of accepted aux requests.

Function
REQ-005 Data memory timing: combinational read, write on the rising clk edge.
REQ-006 The arbiter SHALL drive exactly one owner per cycle onto the mem_* bus, or drive it idle (mem_rd=0, mem_wr=0).
REQ-007 The core requests when core_rd or core_wr is 1; both rd and wr SHALL be passed through unchanged when the core owns the bus.
REQ-008 FSM states: CORE_PRI and AUX_FORCE; reset state CORE_PRI.
REQ-009 CORE_PRI, core requesting: the core owns the bus, core_stall=0, aux_ready=0.
REQ-010 CORE_PRI, core idle with aux_valid=1: aux owns the bus, aux_ready=1, core_stall=0.
REQ-011 Wait counter (4 bit), in CORE_PRI:
- increments when aux_valid=1 and the core wins;
- clears when aux is accepted or aux_valid=0.
REQ-012 CORE_PRI to AUX_FORCE: on the edge where the counter increments to MAX_WAIT.
REQ-013 AUX_FORCE, one cycle only:
- aux owns the bus, aux_ready=aux_valid;
- core_stall=1 if the core is requesting, otherwise 0;
- counter clears; next state is CORE_PRI.
REQ-014 AUX_FORCE with aux_valid=0 (aux withdrew): the bus is idle or given to the core, core_stall=0, return to CORE_PRI.
REQ-015 Aux protocol: aux_valid, aux_we, aux_addr, aux_wdata and aux_func3 are held stable until aux_ready=1; one transfer per ready cycle.
REQ-016 Accepted aux read: aux_rdata SHALL be registered from mem_rdata, with aux_rvalid=1 for exactly one cycle on the following cycle.
REQ-017 Accepted aux write: no aux_rvalid pulse.
REQ-018 core_rdata SHALL equal mem_rdata combinationally whenever the core owns the bus; otherwise it holds 0.
REQ-019 aux_grants SHALL increment by 1 per accepted aux request and saturate at 16'hFFFF.
REQ-020 While core_stall=1 the core request is frozen upstream; the arbiter SHALL serve it in the next CORE_PRI cycle with no loss.
REQ-021 core_stall is combinational from the state and the current request inputs, with no added latency.

Reset
REQ-022 Reset is sampled on the rising clk edge while reset=0.
REQ-023 Reset values: state CORE_PRI, wait counter 0, aux_rvalid 0, aux_rdata 0, aux_grants 0.
REQ-024 While reset=0: mem_rd=0, mem_wr=0, aux_ready=0, core_stall=0.
REQ-025 Reset asserted mid-operation SHALL drop any pending aux read response (no aux_rvalid after reset).
REQ-026 Aux requests SHALL be re-arbitrated from scratch after reset release.

Verification
REQ-027 Core idle, aux read at addr 0x010 holding 0xDEADBEEF -> aux_ready=1 in the same cycle, aux_rvalid=1 with aux_rdata=0xDEADBEEF on the next cycle, aux_grants=1.
REQ-028 Core issues a load every cycle with aux_valid held, MAX_WAIT=4 -> the core wins 4 cycles, 5th cycle aux_ready=1 and core_stall=1, 6th cycle core served with core_stall=0.
REQ-029 Simultaneous core sw 0x11 to 0x020 and aux write 0x22 to 0x020, sustained for MAX_WAIT+1 cycles -> the core write lands first, the aux write lands in the forced cycle, final memory word 0x22.
REQ-030 Aux read accepted, then reset=0 on the next edge -> aux_rvalid stays 0, all reset values hold, aux_grants=0.
REQ-031 Force aux_grants to 16'hFFFE, then complete 3 aux writes -> the count reads FFFF, FFFF, FFFF.
REQ-032 Aux drops aux_valid in the cycle the FSM enters AUX_FORCE -> core_stall=0, the core owns the bus, the state returns to CORE_PRI.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data memory arbiter: shares one combinational-read, edge-write data memory
// between the pipeline MEM stage (priority owner) and a secondary aux
// requester (loader/debug). A bounded wait counter guarantees the aux port
// a forced slot after MAX_WAIT consecutive losses, stalling the core if needed.
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_func3,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_stall,
  input  logic                  aux_valid,
  input  logic                  aux_we,
  input  logic [DM_ADDRESS-1:0] aux_addr,
  input  logic [DATA_W-1:0]     aux_wdata,
  input  logic [2:0]            aux_func3,
  output logic                  aux_ready,
  output logic                  aux_rvalid,
  output logic [DATA_W-1:0]     aux_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [15:0]           aux_grants
);

  typedef enum logic [0:0] {
    CORE_PRI  = 1'b0,
    AUX_FORCE = 1'b1
  } state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_inc;
  logic        core_req;
  logic        core_own;
  logic        aux_own;
  logic        rvalid_q;

  assign core_req = core_rd | core_wr;
  assign wait_inc = wait_cnt + 4'd1;

  // Ownership decision: core has priority except in the single forced aux slot.
  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    core_own   = 1'b0;
    aux_own    = 1'b0;
    core_stall = 1'b0;
    if (reset) begin
      if (state == CORE_PRI) begin
        core_own = core_req;
        aux_own  = ~core_req & aux_valid;
      end else begin
        // Forced slot: aux wins if still asking; a withdrawn aux hands the bus back.
        aux_own    = aux_valid;
        core_own   = ~aux_valid & core_req;
        core_stall = aux_valid & core_req;
      end
    end
  end

  assign aux_ready = aux_own;

  // Memory bus mux: drive the owner's request, or an idle bus.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_func3 = '0;
    if (core_own) begin
      mem_rd    = core_rd;
      mem_wr    = core_wr;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_func3 = core_func3;
    end else if (aux_own) begin
      mem_rd    = ~aux_we;
      mem_wr    = aux_we;
      mem_addr  = aux_addr;
      mem_wdata = aux_wdata;
      mem_func3 = aux_func3;
    end
  end

  assign core_rdata = core_own ? mem_rdata : '0;

  // Arbitration FSM and aux starvation counter.
  // NOTE: sequential state uses non-blocking assignments and the reset is sampled synchronously inside the clocked block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= CORE_PRI;
      wait_cnt <= '0;
    end else begin
      case (state)
        CORE_PRI: begin
          if (aux_valid && core_req) begin
            wait_cnt <= wait_inc;
            if (wait_inc == MAX_WAIT_C) state <= AUX_FORCE;
          end else begin
            wait_cnt <= '0;
          end
        end
        AUX_FORCE: begin
          wait_cnt <= '0;
          state    <= CORE_PRI;
        end
        default: begin
          wait_cnt <= '0;
          state    <= CORE_PRI;
        end
      endcase
    end
  end

  // Aux read response register and saturating grant counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rvalid_q   <= 1'b0;
      aux_rdata  <= '0;
      aux_grants <= '0;
    end else begin
      rvalid_q <= aux_own & ~aux_we;
      if (aux_own && !aux_we) aux_rdata <= mem_rdata;
      if (aux_own && (aux_grants != 16'hFFFF)) aux_grants <= aux_grants + 16'd1;
    end
  end

  // A response pending when reset arrives is never presented.
  assign aux_rvalid = rvalid_q & reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a behavioural ownership/memory model
// runs alongside the DUT every cycle, with directed scenarios and random traffic.
module tb_dmem_arbiter;

  localparam int DATA_W     = 32;
  localparam int DM_ADDRESS = 9;
  localparam int MAX_WAIT   = 4;

  logic                  clk;
  logic                  reset;
  logic                  core_rd, core_wr;
  logic [DM_ADDRESS-1:0] core_addr;
  logic [DATA_W-1:0]     core_wdata;
  logic [2:0]            core_func3;
  logic [DATA_W-1:0]     core_rdata;
  logic                  core_stall;
  logic                  aux_valid, aux_we;
  logic [DM_ADDRESS-1:0] aux_addr;
  logic [DATA_W-1:0]     aux_wdata;
  logic [2:0]            aux_func3;
  logic                  aux_ready, aux_rvalid;
  logic [DATA_W-1:0]     aux_rdata;
  logic                  mem_rd, mem_wr;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [2:0]            mem_func3;
  logic [DATA_W-1:0]     mem_rdata;
  logic [15:0]           aux_grants;

  dmem_arbiter #(.DATA_W(DATA_W), .DM_ADDRESS(DM_ADDRESS), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_func3(core_func3),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .aux_valid(aux_valid), .aux_we(aux_we), .aux_addr(aux_addr),
    .aux_wdata(aux_wdata), .aux_func3(aux_func3),
    .aux_ready(aux_ready), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata),
    .aux_grants(aux_grants)
  );

  // Data memory: combinational read, write on the rising edge; preload port for setup.
  logic [DATA_W-1:0]     dm [512];
  logic                  pl_we;
  logic [DM_ADDRESS-1:0] pl_addr;
  logic [DATA_W-1:0]     pl_data;

  always @(posedge clk) begin
    if (pl_we) dm[pl_addr] <= pl_data;
    else if (mem_wr) dm[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = dm[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  bit quiet  = 1'b0;

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [512];
  int                m_losses = 0;
  bit                m_force  = 1'b0;
  bit                m_rvalid = 1'b0;
  logic [DATA_W-1:0] m_rdata  = '0;
  int                m_grants = 0;
  int                last_owner = 0;
  bit                last_stall_exp = 1'b0;
  logic              last_ready, last_stall, last_mem_rd, last_mem_wr, last_rvalid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare all outputs with the model, then advance the model across the edge.
  task automatic cycle();
    int   owner;
    logic creq, e_rd, e_wr, e_stall;
    logic [DM_ADDRESS-1:0] e_addr;
    logic [DATA_W-1:0]     e_wdata, e_crdata;
    logic [2:0]            e_f3;
    @(negedge clk);
    creq = core_rd | core_wr;
    if (!reset)          owner = 0;
    else if (m_force)    owner = aux_valid ? 2 : (creq ? 1 : 0);
    else                 owner = creq ? 1 : (aux_valid ? 2 : 0);
    e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0; e_f3 = '0;
    if (owner == 1) begin
      e_rd = core_rd; e_wr = core_wr; e_addr = core_addr; e_wdata = core_wdata; e_f3 = core_func3;
    end else if (owner == 2) begin
      e_rd = ~aux_we; e_wr = aux_we; e_addr = aux_addr; e_wdata = aux_wdata; e_f3 = aux_func3;
    end
    e_stall  = reset && m_force && aux_valid && creq;
    e_crdata = (owner == 1) ? ref_mem[core_addr] : '0;
    last_ready = aux_ready; last_stall = core_stall;
    last_mem_rd = mem_rd; last_mem_wr = mem_wr; last_rvalid = aux_rvalid;
    if (!quiet) begin
      check("mem_rd", mem_rd, e_rd);
      check("mem_wr", mem_wr, e_wr);
      if (owner != 0) begin
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wdata);
        check("mem_func3", mem_func3, e_f3);
      end
      check("core_stall", core_stall, e_stall);
      check("aux_ready", aux_ready, owner == 2);
      check("core_rdata", core_rdata, e_crdata);
      check("aux_rvalid", aux_rvalid, m_rvalid && reset);
      check("aux_rdata", aux_rdata, m_rdata);
      check("aux_grants", aux_grants, m_grants);
    end
    // Edge update.
    if (!reset) begin
      m_losses = 0; m_force = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_grants = 0;
    end else begin
      m_rvalid = (owner == 2) && !aux_we;
      if (owner == 2 && !aux_we) m_rdata = ref_mem[aux_addr];
      if (owner == 2 && m_grants < 65535) m_grants++;
      if (owner == 1 && core_wr) ref_mem[core_addr] = core_wdata;
      if (owner == 2 && aux_we)  ref_mem[aux_addr]  = aux_wdata;
      if (m_force) begin
        m_force = 1'b0; m_losses = 0;
      end else if (owner == 1 && aux_valid) begin
        m_losses++;
        if (m_losses == MAX_WAIT) m_force = 1'b1;
      end else begin
        m_losses = 0;
      end
    end
    if (pl_we) ref_mem[pl_addr] = pl_data;
    last_owner = owner;
    last_stall_exp = e_stall;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_core(input logic rd, input logic wr, input int addr, input logic [DATA_W-1:0] wd);
    core_rd = rd; core_wr = wr; core_addr = DM_ADDRESS'(addr); core_wdata = wd; core_func3 = 3'b010;
  endtask

  task automatic drive_aux(input logic v, input logic we, input int addr, input logic [DATA_W-1:0] wd);
    aux_valid = v; aux_we = we; aux_addr = DM_ADDRESS'(addr); aux_wdata = wd; aux_func3 = 3'b010;
  endtask

  initial begin
    reset = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    drive_core(1'b1, 1'b0, 5, 32'h0);
    drive_aux(1'b1, 1'b0, 6, 32'h0);
    @(posedge clk); #1;

    // Reset with both requesters active; preload the memory meanwhile.
    for (int i = 0; i < 512; i++) begin
      pl_we = 1'b1; pl_addr = DM_ADDRESS'(i);
      pl_data = (i == 'h010) ? 32'hDEADBEEF : $urandom;
      cycle();
      if (i == 0) begin
        check("rst_mem_rd", last_mem_rd, 1'b0);
        check("rst_aux_ready", last_ready, 1'b0);
        check("rst_core_stall", last_stall, 1'b0);
      end
    end
    pl_we = 1'b0;
    check("rst_grants", aux_grants, 16'h0);
    check("rst_rvalid", aux_rvalid, 1'b0);
    reset = 1'b1;

    // Core idle, aux read of 0x010.
    drive_core(1'b0, 1'b0, 0, 32'h0);
    drive_aux(1'b1, 1'b0, 'h010, 32'h0);
    cycle();
    check("r027_ready", last_ready, 1'b1);
    drive_aux(1'b0, 1'b0, 0, 32'h0);
    cycle();
    check("r027_rvalid", last_rvalid, 1'b1);
    check("r027_rdata", aux_rdata, 32'hDEADBEEF);
    check("r027_grants", aux_grants, 16'd1);

    // Core loads every cycle while aux waits: four losses, then a forced slot.
    drive_aux(1'b1, 1'b0, 'h030, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      drive_core(1'b1, 1'b0, 'h040 + i, 32'h0);
      if (i == 6) drive_aux(1'b0, 1'b0, 0, 32'h0);
      cycle();
      check("r028_ready", last_ready, i == 5);
      check("r028_stall", last_stall, i == 5);
      if (i == 6) check("r028_served", last_mem_rd, 1'b1);
    end
    drive_core(1'b0, 1'b0, 0, 32'h0);
    cycle();

    // Core and aux store to the same word; aux lands last in the forced slot.
    drive_core(1'b0, 1'b1, 'h020, 32'h11);
    drive_aux(1'b1, 1'b1, 'h020, 32'h22);
    for (int i = 1; i <= MAX_WAIT + 1; i++) begin
      cycle();
      if (i == 1) check("r029_core_first", dm['h020], 32'h11);
    end
    drive_core(1'b0, 1'b0, 0, 32'h0);
    drive_aux(1'b0, 1'b0, 0, 32'h0);
    cycle();
    check("r029_final", dm['h020], 32'h22);

    // Aux withdraws exactly when the forced slot arrives.
    drive_aux(1'b1, 1'b0, 'h050, 32'h0);
    for (int i = 1; i <= MAX_WAIT; i++) begin
      drive_core(1'b1, 1'b0, 'h060 + i, 32'h0);
      cycle();
    end
    drive_aux(1'b0, 1'b0, 0, 32'h0);
    cycle();
    check("r032_stall", last_stall, 1'b0);
    check("r032_core_owns", last_mem_rd, 1'b1);
    check("r032_ready", last_ready, 1'b0);
    drive_aux(1'b1, 1'b0, 'h050, 32'h0);
    cycle();
    check("r032_back_core_pri", last_ready, 1'b0);
    drive_core(1'b0, 1'b0, 0, 32'h0);
    cycle();

    // Random traffic with protocol-correct holding of stalled/pending requests.
    for (int i = 0; i < 600; i++) begin
      if (!last_stall_exp) begin
        case ($urandom_range(0, 3))
          0:       drive_core(1'b0, 1'b0, $urandom_range(0, 31), $urandom);
          1, 2:    drive_core(1'b1, 1'b0, $urandom_range(0, 31), $urandom);
          default: drive_core(1'b0, 1'b1, $urandom_range(0, 31), $urandom);
        endcase
        core_func3 = 3'($urandom_range(0, 7));
      end
      if (!aux_valid || last_owner == 2) begin
        drive_aux($urandom_range(0, 2) != 0, 1'($urandom), $urandom_range(0, 31), $urandom);
        aux_func3 = 3'($urandom_range(0, 7));
      end
      cycle();
    end

    // Reset right after an accepted aux read drops the response.
    drive_core(1'b0, 1'b0, 0, 32'h0);
    drive_aux(1'b0, 1'b0, 0, 32'h0);
    cycle();
    drive_aux(1'b1, 1'b0, 'h010, 32'h0);
    cycle();
    check("r030_accept", last_ready, 1'b1);
    reset = 1'b0;
    drive_core(1'b1, 1'b0, 3, 32'h0);
    cycle();
    check("r030_rvalid_in_rst", last_rvalid, 1'b0);
    cycle();
    reset = 1'b1;
    drive_core(1'b0, 1'b0, 0, 32'h0);
    drive_aux(1'b0, 1'b0, 0, 32'h0);
    cycle();
    check("r030_rvalid", aux_rvalid, 1'b0);
    check("r030_rdata", aux_rdata, 32'h0);
    check("r030_grants", aux_grants, 16'h0);

    // Bring the grant counter to 0xFFFE, then three more writes saturate it.
    drive_aux(1'b1, 1'b1, 'h100, 32'h5A5A5A5A);
    quiet = 1'b1;
    for (int i = 0; i < 65534; i++) cycle();
    quiet = 1'b0;
    check("r031_pre", aux_grants, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("r031_sat", aux_grants, 16'hFFFF);
    end
    drive_aux(1'b0, 1'b0, 0, 32'h0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
